// File: rtl/pad_poll_pkg.sv
// Shared definitions for the serial game-pad poller.
// Holds the FSM encoding and the NES/SNES defaults for a 50 MHz clock.
package pad_poll_pkg;

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} poll_state_t;

  localparam int NES_BITS            = 8;
  localparam int SNES_BITS           = 16;
  localparam int LATCH_CYCLES_50M    = 600;
  localparam int HALF_BIT_CYCLES_50M = 300;
  localparam int POLL_CYCLES_50M     = 833333;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pad_shift_capture.sv
// One pad channel: two-flop synchronizer on the serial line plus a capture
// register written one bit at a time (inverted, so 1 = pressed).
module pad_shift_capture
  import pad_poll_pkg::*;
#(
  parameter int NUM_BITS = NES_BITS,
  parameter int IDX_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data,
  input  logic                sample,
  input  logic [IDX_W-1:0]    bit_idx,
  output logic [NUM_BITS-1:0] bits
);

  logic data_p0;
  logic data_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= 1'b0;
      data_p1 <= 1'b0;
      bits    <= '0;
    end else begin
      // synchronizer stage boundary: data_p1 is safe to use
      data_p0 <= data;
      data_p1 <= data_p0;
      if (sample) begin
        bits[bit_idx] <= ~data_p1;
      end
    end
  end

endmodule

// File: rtl/pad_serial_poller.sv
// Polls NUM_CH serial game pads in lock-step on a shared latch/pulse pair and
// publishes the captured button words once per frame.
module pad_serial_poller
  import pad_poll_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int NUM_BITS        = NES_BITS,
  parameter int LATCH_CYCLES    = LATCH_CYCLES_50M,
  parameter int HALF_BIT_CYCLES = HALF_BIT_CYCLES_50M,
  parameter int POLL_CYCLES     = POLL_CYCLES_50M
) (
  input  logic                       Clk_In,
  input  logic                       Reset_In,
  input  logic                       Enable_In,
  input  logic [NUM_CH-1:0]          Data_In,
  output logic                       Latch_Out,
  output logic                       Pulse_Out,
  output logic [NUM_CH*NUM_BITS-1:0] Buttons_Out,
  output logic                       Valid_Out,
  output logic                       Busy_Out,
  output logic                       Overrun_Out
);

  localparam int PHASE_W = $clog2(max_int(LATCH_CYCLES, HALF_BIT_CYCLES));
  localparam int POLL_W  = $clog2(POLL_CYCLES);
  localparam int BIT_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  poll_state_t                state;
  poll_state_t                state_n;
  logic [POLL_W-1:0]          poll_cnt;
  logic [PHASE_W-1:0]         phase_cnt;
  logic [BIT_W-1:0]           bit_cnt;
  logic                       poll_tick;
  logic                       phase_last;
  logic                       bit_last;
  logic                       sample;
  logic                       latch_nx;
  logic                       pulse_nx;
  logic                       busy_nx;
  logic                       done_nx;
  logic [NUM_CH*NUM_BITS-1:0] captured;

  assign poll_tick = (poll_cnt == POLL_W'(POLL_CYCLES - 1));
  assign bit_last  = (bit_cnt == BIT_W'(NUM_BITS - 1));

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    phase_last = 1'b0;
    if (state == LATCH) begin
      phase_last = (phase_cnt == PHASE_W'(LATCH_CYCLES - 1));
    end else begin
      phase_last = (phase_cnt == PHASE_W'(HALF_BIT_CYCLES - 1));
    end
    case (state)
      IDLE:    if (poll_tick && Enable_In) state_n = LATCH;
      LATCH:   if (phase_last) state_n = LOW;
      LOW:     if (phase_last) state_n = HIGH;
      HIGH:    if (phase_last) state_n = bit_last ? DONE : LOW;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    latch_nx = (state_n == LATCH);
    pulse_nx = (state_n == HIGH);
    busy_nx  = (state_n != IDLE);
    done_nx  = (state_n == DONE);
    sample   = (state == LOW) && phase_last;
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      poll_cnt  <= '0;
      phase_cnt <= '0;
      bit_cnt   <= '0;
    end else begin
      poll_cnt <= poll_tick ? '0 : poll_cnt + POLL_W'(1);
      if (state_n != state) begin
        phase_cnt <= '0;
      end else if (state != IDLE) begin
        phase_cnt <= phase_cnt + PHASE_W'(1);
      end
      if (state == LATCH) begin
        bit_cnt <= '0;
      end else if ((state == HIGH) && phase_last) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      Latch_Out   <= 1'b0;
      Pulse_Out   <= 1'b0;
      Busy_Out    <= 1'b0;
      Valid_Out   <= 1'b0;
      Overrun_Out <= 1'b0;
      Buttons_Out <= '0;
    end else begin
      Latch_Out <= latch_nx;
      Pulse_Out <= pulse_nx;
      Busy_Out  <= busy_nx;
      Valid_Out <= done_nx;
      // A tick that lands on a busy frame is dropped, never queued.
      if (poll_tick && (state != IDLE)) begin
        Overrun_Out <= 1'b1;
      end
      if (done_nx) begin
        Buttons_Out <= captured;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pad_shift_capture #(
      .NUM_BITS (NUM_BITS),
      .IDX_W    (BIT_W)
    ) u_cap (
      .clk     (Clk_In),
      .rst     (Reset_In),
      .data    (Data_In[c]),
      .sample  (sample),
      .bit_idx (bit_cnt),
      .bits    (captured[c*NUM_BITS +: NUM_BITS])
    );
  end

endmodule

// File: tb/tb_pad_serial_poller.sv
// Directed bench for pad_serial_poller: behavioural pads shift out fixed patterns
// and each scenario task checks frame timing and captured button words.
module tb_pad_serial_poller;

  logic        clk = 1'b0;
  int          total;
  int          bad;
  int          cyc;

  // DUT a: 2 pads x 8 bits, poll 100
  logic        rst_a, en_a, latch_a, pulse_a, valid_a, busy_a, ovr_a;
  logic [1:0]  data_a;
  logic [15:0] btn_a;
  logic [7:0]  pat_a0, pat_a1;
  logic [2:0]  idx_a = '0;
  logic        pd_a = 1'b0;

  // DUT b: 2 pads x 8 bits, poll 40 (shorter than a frame)
  logic        rst_b, en_b, latch_b, pulse_b, valid_b, busy_b, ovr_b;
  logic [1:0]  data_b;
  logic [15:0] btn_b;

  // DUT c: 1 pad x 16 bits, poll 100
  logic        rst_c, en_c, latch_c, pulse_c, valid_c, busy_c, ovr_c;
  logic [0:0]  data_c;
  logic [15:0] btn_c;
  logic [15:0] pat_c;
  logic [3:0]  idx_c = '0;
  logic        pd_c = 1'b0;

  always #5 clk = ~clk;

  pad_serial_poller #(.NUM_CH(2), .NUM_BITS(8), .LATCH_CYCLES(4), .HALF_BIT_CYCLES(3),
                      .POLL_CYCLES(100)) u_a (
    .Clk_In(clk), .Reset_In(rst_a), .Enable_In(en_a), .Data_In(data_a),
    .Latch_Out(latch_a), .Pulse_Out(pulse_a), .Buttons_Out(btn_a),
    .Valid_Out(valid_a), .Busy_Out(busy_a), .Overrun_Out(ovr_a));

  pad_serial_poller #(.NUM_CH(2), .NUM_BITS(8), .LATCH_CYCLES(4), .HALF_BIT_CYCLES(3),
                      .POLL_CYCLES(40)) u_b (
    .Clk_In(clk), .Reset_In(rst_b), .Enable_In(en_b), .Data_In(data_b),
    .Latch_Out(latch_b), .Pulse_Out(pulse_b), .Buttons_Out(btn_b),
    .Valid_Out(valid_b), .Busy_Out(busy_b), .Overrun_Out(ovr_b));

  pad_serial_poller #(.NUM_CH(1), .NUM_BITS(16), .LATCH_CYCLES(4), .HALF_BIT_CYCLES(3),
                      .POLL_CYCLES(100)) u_c (
    .Clk_In(clk), .Reset_In(rst_c), .Enable_In(en_c), .Data_In(data_c),
    .Latch_Out(latch_c), .Pulse_Out(pulse_c), .Buttons_Out(btn_c),
    .Valid_Out(valid_c), .Busy_Out(busy_c), .Overrun_Out(ovr_c));

  // Pad models: latch reloads bit 0, each rising shift clock advances one bit.
  always @(posedge clk) begin
    pd_a <= pulse_a;
    if (latch_a) idx_a <= '0;
    else if (pulse_a && !pd_a) idx_a <= idx_a + 3'd1;
    pd_c <= pulse_c;
    if (latch_c) idx_c <= '0;
    else if (pulse_c && !pd_c) idx_c <= idx_c + 4'd1;
  end

  assign data_a = {~pat_a1[idx_a], ~pat_a0[idx_a]};
  assign data_b = 2'b11;
  assign data_c = ~pat_c[idx_c];

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    total++;
    if ({latch_a, pulse_a, busy_a, valid_a, ovr_a} !== 5'b0) begin
      bad++; $display("FAIL rst_ctrl_held got=%b exp=00000", {latch_a, pulse_a, busy_a, valid_a, ovr_a});
    end
    total++;
    if (btn_a !== 16'h0000) begin bad++; $display("FAIL rst_btn_held got=%h exp=0000", btn_a); end
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    cyc = 0;
    total++;
    if ({latch_a, pulse_a, busy_a, valid_a, ovr_a} !== 5'b0) begin
      bad++; $display("FAIL rst_ctrl_c0 got=%b exp=00000", {latch_a, pulse_a, busy_a, valid_a, ovr_a});
    end
  endtask

  task automatic test_frame();
    int first_latch, latch_n, rise_n, bad_run, run, vcyc, vcnt, busy_n, both;
    logic [15:0] vbtn;
    logic pprev;
    first_latch = -1; latch_n = 0; rise_n = 0; bad_run = 0; run = 0;
    vcyc = -1; vcnt = 0; busy_n = 0; both = 0; vbtn = 16'hxxxx; pprev = 1'b0;
    while (cyc < 190) begin
      if (latch_a && first_latch < 0) first_latch = cyc;
      if (latch_a) latch_n++;
      if (latch_a && pulse_a) both++;
      if (pulse_a) run++;
      if (pulse_a && !pprev) rise_n++;
      if (!pulse_a && pprev) begin
        if (run != 3) bad_run++;
        run = 0;
      end
      pprev = pulse_a;
      if (busy_a) busy_n++;
      if (valid_a) begin vcnt++; vcyc = cyc; vbtn = btn_a; end
      step();
    end
    total++; if (first_latch !== 100) begin bad++; $display("FAIL t1_latch_start got=%0d exp=100", first_latch); end
    total++; if (latch_n !== 4) begin bad++; $display("FAIL t1_latch_len got=%0d exp=4", latch_n); end
    total++; if (rise_n !== 8) begin bad++; $display("FAIL t1_pulse_count got=%0d exp=8", rise_n); end
    total++; if (bad_run !== 0) begin bad++; $display("FAIL t1_pulse_width got=%0d bad runs exp=0", bad_run); end
    total++; if (both !== 0) begin bad++; $display("FAIL t1_latch_pulse_overlap got=%0d exp=0", both); end
    total++; if (vcyc !== 152) begin bad++; $display("FAIL t1_valid_cycle got=%0d exp=152", vcyc); end
    total++; if (vcnt !== 1) begin bad++; $display("FAIL t1_valid_count got=%0d exp=1", vcnt); end
    total++; if (vbtn !== 16'h0000) begin bad++; $display("FAIL t1_buttons got=%h exp=0000", vbtn); end
    total++; if (busy_n !== 53) begin bad++; $display("FAIL t1_busy_len got=%0d exp=53", busy_n); end
    total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL t1_no_overrun got=%b exp=0", ovr_a); end
  endtask

  task automatic test_back_to_back();
    int vcyc, vcnt;
    logic [15:0] vbtn;
    pat_a0 = 8'hA5; pat_a1 = 8'h81;
    vcyc = -1; vcnt = 0; vbtn = 16'hxxxx;
    while (cyc < 260) begin
      if (valid_a) begin vcnt++; vcyc = cyc; vbtn = btn_a; end
      step();
    end
    total++; if (vcyc !== 252) begin bad++; $display("FAIL t2_valid_cycle got=%0d exp=252", vcyc); end
    total++; if (vcnt !== 1) begin bad++; $display("FAIL t2_valid_count got=%0d exp=1", vcnt); end
    total++; if (vbtn !== 16'h81A5) begin bad++; $display("FAIL t2_buttons got=%h exp=81a5", vbtn); end
    total++; if (btn_a !== 16'h81A5) begin bad++; $display("FAIL t2_buttons_hold got=%h exp=81a5", btn_a); end
  endtask

  task automatic test_enable_drop();
    int vcyc, vcnt, late;
    logic [15:0] vbtn;
    pat_a0 = 8'h3C; pat_a1 = 8'h0F;
    vcyc = -1; vcnt = 0; late = 0; vbtn = 16'hxxxx;
    while (cyc < 600) begin
      if (cyc == 320) en_a = 1'b0;
      if (cyc == 510) en_a = 1'b1;
      if (valid_a) begin vcnt++; vcyc = cyc; vbtn = btn_a; end
      if (cyc > 352 && (latch_a || busy_a)) late++;
      step();
    end
    total++; if (vcyc !== 352) begin bad++; $display("FAIL t5_valid_cycle got=%0d exp=352", vcyc); end
    total++; if (vcnt !== 1) begin bad++; $display("FAIL t5_valid_count got=%0d exp=1", vcnt); end
    total++; if (vbtn !== 16'h0F3C) begin bad++; $display("FAIL t5_buttons got=%h exp=0f3c", vbtn); end
    total++; if (late !== 0) begin bad++; $display("FAIL t5_idle_while_disabled got=%0d busy cycles exp=0", late); end
    total++; if (latch_a !== 1'b1) begin bad++; $display("FAIL t5_restart_latch got=%b exp=1", latch_a); end
  endtask

  task automatic test_reset_mid_frame();
    int vcnt, first_latch;
    while (cyc < 623) step();
    total++;
    if ({busy_a, pulse_a} !== 2'b10) begin
      bad++; $display("FAIL t4_in_low3 got busy,pulse=%b exp=10", {busy_a, pulse_a});
    end
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    cyc = 0;
    total++;
    if ({latch_a, pulse_a, busy_a, valid_a} !== 4'b0) begin
      bad++; $display("FAIL t4_ctrl_cleared got=%b exp=0000", {latch_a, pulse_a, busy_a, valid_a});
    end
    total++; if (btn_a !== 16'h0000) begin bad++; $display("FAIL t4_buttons_cleared got=%h exp=0000", btn_a); end
    vcnt = 0; first_latch = -1;
    while (cyc <= 100) begin
      if (valid_a) vcnt++;
      if (latch_a && first_latch < 0) first_latch = cyc;
      step();
    end
    total++; if (vcnt !== 0) begin bad++; $display("FAIL t4_no_valid got=%0d exp=0", vcnt); end
    total++; if (first_latch !== 100) begin bad++; $display("FAIL t4_next_frame got=%0d exp=100", first_latch); end
  endtask

  task automatic test_overrun();
    int vq[$];
    int ov_drop, g0, g1, g2;
    logic ov79, ov80;
    ov_drop = 0; ov79 = 1'bx; ov80 = 1'bx;
    rst_b = 1'b0;
    cyc = 0;
    while (cyc < 260) begin
      if (cyc == 79) ov79 = ovr_b;
      if (cyc == 80) ov80 = ovr_b;
      if (cyc > 80 && !ovr_b) ov_drop++;
      if (valid_b) vq.push_back(cyc);
      step();
    end
    g0 = (vq.size() > 0) ? vq[0] : -1;
    g1 = (vq.size() > 1) ? vq[1] : -1;
    g2 = (vq.size() > 2) ? vq[2] : -1;
    total++; if (ov79 !== 1'b0) begin bad++; $display("FAIL t3_ovr_before got=%b exp=0", ov79); end
    total++; if (ov80 !== 1'b1) begin bad++; $display("FAIL t3_ovr_set got=%b exp=1", ov80); end
    total++; if (ov_drop !== 0) begin bad++; $display("FAIL t3_ovr_sticky got=%0d low cycles exp=0", ov_drop); end
    total++; if (vq.size() !== 3) begin bad++; $display("FAIL t3_frame_count got=%0d exp=3", vq.size()); end
    total++;
    if (g0 !== 92 || g1 !== 172 || g2 !== 252) begin
      bad++; $display("FAIL t3_valid_cycles got=%0d,%0d,%0d exp=92,172,252", g0, g1, g2);
    end
  endtask

  task automatic test_snes();
    int vcyc, vcnt, first_latch;
    logic [15:0] vbtn;
    vcyc = -1; vcnt = 0; first_latch = -1; vbtn = 16'hxxxx;
    rst_c = 1'b0;
    cyc = 0;
    while (cyc < 210) begin
      if (latch_c && first_latch < 0) first_latch = cyc;
      if (valid_c) begin vcnt++; vcyc = cyc; vbtn = btn_c; end
      step();
    end
    total++; if (first_latch !== 100) begin bad++; $display("FAIL t6_latch_start got=%0d exp=100", first_latch); end
    total++; if (vcyc !== 200) begin bad++; $display("FAIL t6_valid_cycle got=%0d exp=200", vcyc); end
    total++; if (vcnt !== 1) begin bad++; $display("FAIL t6_valid_count got=%0d exp=1", vcnt); end
    total++; if (vbtn !== 16'hC3F0) begin bad++; $display("FAIL t6_buttons got=%h exp=c3f0", vbtn); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    pat_a0 = 8'h00; pat_a1 = 8'h00; pat_c = 16'hC3F0;
    @(negedge clk);
    test_reset();
    test_frame();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    test_overrun();
    test_snes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
